// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
//   Command-driven controller for the stack/TOS datapath. It takes one command at a
//   time (PUSH, POP, STORE, LOAD, RESTORE) over a valid/ready handshake and expands
//   it into the per-cycle register, mux and write-enable controls for the datapath.
//   It tracks a shadow copy of TOS (depth) and rejects commands that would overflow
//   or underflow the stack, or that carry an illegal opcode.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; ready only while idle
//   cmd_op/cmd_src/cmd_tos     opcode, PUSH mux source, RESTORE value
//   done                       pulse in the last cycle of a command
//   err_valid/err_code         pulse the cycle after a rejected accept
//   depth                      shadow TOS
//   ctrl_*/sel_*               Moore datapath controls
module stack_op_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [2:0]            cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_tos,
  output logic                  done,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  ctrl_reg_read_stack,
  output logic                  ctrl_reg_write_stack,
  output logic                  ctrl_reg_read_mem,
  output logic                  ctrl_reg_write_mem,
  output logic                  ctrl_reg_tos,
  output logic                  sel_mux_tos,
  output logic                  sel_tos_updater,
  output logic                  ctrl_stack,
  output logic                  ctrl_mem_ext,
  output logic [2:0]            sel_mux_stack
);

  localparam logic [2:0] OP_PUSH    = 3'd0;
  localparam logic [2:0] OP_POP     = 3'd1;
  localparam logic [2:0] OP_STORE   = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_RESTORE = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_ILLEG = 2'b11;

  // Last value of the wait counter before the capture state; unused when RD_LAT=0.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_WAIT, S_POP_CAP, S_POP_DEC, S_ST_CAP, S_ST_WRITE, S_ST_DEC,
    S_LD_WAIT, S_LD_CAP, S_PUSH_LATCH, S_PUSH_WRITE, S_RESTORE
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            op_q, src_q;
  logic [ADDR_WIDTH-1:0] tos_q, depth_q;
  logic                  load_q;
  logic [1:0]            wait_cnt;
  logic                  accept;
  logic [1:0]            rej_code;

  assign accept = cmd_valid && (state == S_IDLE);
  assign depth  = depth_q;

  // Rejection is decided against the depth seen at accept time.
  always_comb begin
    rej_code = ERR_NONE;
    if (cmd_op > OP_RESTORE)
      rej_code = ERR_ILLEG;
    else if ((cmd_op == OP_PUSH || cmd_op == OP_LOAD) && depth_q == '1)
      rej_code = ERR_OVF;
    else if ((cmd_op == OP_POP || cmd_op == OP_STORE) && depth_q == '0)
      rej_code = ERR_UNF;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && rej_code == ERR_NONE) begin
        case (cmd_op)
          OP_PUSH:  state_nxt = S_PUSH_LATCH;
          OP_POP:   state_nxt = (RD_LAT == 0) ? S_POP_CAP : S_RD_WAIT;
          OP_STORE: state_nxt = (RD_LAT == 0) ? S_ST_CAP : S_RD_WAIT;
          OP_LOAD:  state_nxt = (RD_LAT == 0) ? S_LD_CAP : S_LD_WAIT;
          default:  state_nxt = S_RESTORE;
        endcase
      end
      S_RD_WAIT:    if (wait_cnt == WAIT_LAST)
                      state_nxt = (op_q == OP_POP) ? S_POP_CAP : S_ST_CAP;
      S_POP_CAP:    state_nxt = S_POP_DEC;
      S_ST_CAP:     state_nxt = S_ST_WRITE;
      S_ST_WRITE:   state_nxt = S_ST_DEC;
      S_LD_WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = S_LD_CAP;
      S_LD_CAP:     state_nxt = S_PUSH_LATCH;
      S_PUSH_LATCH: state_nxt = S_PUSH_WRITE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      src_q     <= '0;
      tos_q     <= '0;
      load_q    <= 1'b0;
      wait_cnt  <= '0;
      depth_q   <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      err_valid <= accept && (rej_code != ERR_NONE);
      err_code  <= accept ? rej_code : ERR_NONE;
      if (accept) begin
        op_q   <= cmd_op;
        src_q  <= cmd_src;
        tos_q  <= cmd_tos;
        load_q <= (cmd_op == OP_LOAD);
      end
      // Counter only runs inside a wait state, so it is zero on every entry.
      wait_cnt <= (state == S_RD_WAIT || state == S_LD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
      case (state)
        S_PUSH_LATCH:        depth_q <= depth_q + ADDR_WIDTH'(1);
        S_POP_DEC, S_ST_DEC: depth_q <= depth_q - ADDR_WIDTH'(1);
        S_RESTORE:           depth_q <= tos_q;
        default:             ;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    cmd_ready            = (state == S_IDLE);
    done                 = 1'b0;
    ctrl_reg_read_stack  = 1'b0;
    ctrl_reg_write_stack = 1'b0;
    ctrl_reg_read_mem    = 1'b0;
    ctrl_reg_write_mem   = 1'b0;
    ctrl_reg_tos         = 1'b0;
    sel_mux_tos          = 1'b0;
    sel_tos_updater      = 1'b0;
    ctrl_stack           = 1'b0;
    ctrl_mem_ext         = 1'b0;
    sel_mux_stack        = 3'b000;
    case (state)
      S_PUSH_LATCH: begin
        ctrl_reg_write_stack = 1'b1;
        ctrl_reg_tos         = 1'b1;
        // LOAD pushes the word just captured from external memory.
        sel_mux_stack        = load_q ? 3'b001 : src_q;
      end
      S_PUSH_WRITE: begin
        ctrl_stack = 1'b1;
        done       = 1'b1;
      end
      S_POP_CAP:  ctrl_reg_read_stack = 1'b1;
      S_ST_CAP:   ctrl_reg_write_mem  = 1'b1;
      S_ST_WRITE: ctrl_mem_ext        = 1'b1;
      S_LD_CAP:   ctrl_reg_read_mem   = 1'b1;
      S_POP_DEC, S_ST_DEC: begin
        ctrl_reg_tos    = 1'b1;
        sel_tos_updater = 1'b1;
        done            = 1'b1;
      end
      S_RESTORE: begin
        ctrl_reg_tos = 1'b1;
        sel_mux_tos  = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer (ADDR_WIDTH=3, RD_LAT=1). A reference model keeps
// the stack depth as an integer and lists, per command, the expected control word
// for every busy cycle; directed steps come first, then randomized commands.
module tb_stack_op_sequencer;
  localparam int AW   = 3;
  localparam int LAT  = 1;
  localparam int MAXD = (1 << AW) - 1;

  // Bit positions of the packed observation word.
  localparam int RS = 12, WS = 11, RM = 10, WM = 9, RT = 8, SMT = 7, UPD = 6,
                 CS = 5, ME = 4, DN = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op, cmd_src;
  logic [AW-1:0] cmd_tos;
  logic          done, err_valid;
  logic [1:0]    err_code;
  logic [AW-1:0] depth;
  logic          ctrl_reg_read_stack, ctrl_reg_write_stack, ctrl_reg_read_mem;
  logic          ctrl_reg_write_mem, ctrl_reg_tos, sel_mux_tos, sel_tos_updater;
  logic          ctrl_stack, ctrl_mem_ext;
  logic [2:0]    sel_mux_stack;

  stack_op_sequencer #(.ADDR_WIDTH(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_tos(cmd_tos), .done(done),
    .err_valid(err_valid), .err_code(err_code), .depth(depth),
    .ctrl_reg_read_stack(ctrl_reg_read_stack), .ctrl_reg_write_stack(ctrl_reg_write_stack),
    .ctrl_reg_read_mem(ctrl_reg_read_mem), .ctrl_reg_write_mem(ctrl_reg_write_mem),
    .ctrl_reg_tos(ctrl_reg_tos), .sel_mux_tos(sel_mux_tos), .sel_tos_updater(sel_tos_updater),
    .ctrl_stack(ctrl_stack), .ctrl_mem_ext(ctrl_mem_ext), .sel_mux_stack(sel_mux_stack)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {ctrl_reg_read_stack, ctrl_reg_write_stack, ctrl_reg_read_mem,
                ctrl_reg_write_mem, ctrl_reg_tos, sel_mux_tos, sel_tos_updater,
                ctrl_stack, ctrl_mem_ext, sel_mux_stack, done};

  typedef struct { int word; int dep; } step_t;
  step_t exp_q[$];
  int    md;          // model depth
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic void push_step(input int w);
    step_t s;
    s.word = w;
    s.dep  = md;
    exp_q.push_back(s);
  endfunction

  // Build expected per-cycle trace from the command rules; returns reject code.
  task automatic build(input int op, input int src, input int tos, output int code);
    exp_q.delete();
    code = 0;
    if (op > 4) code = 3;
    else if ((op == 0 || op == 3) && md == MAXD) code = 1;
    else if ((op == 1 || op == 2) && md == 0) code = 2;
    if (code != 0) return;
    case (op)
      0: begin
        push_step((1 << WS) | (1 << RT) | (src << 1));
        md++;
        push_step((1 << CS) | (1 << DN));
      end
      1: begin
        for (int i = 0; i < LAT; i++) push_step(0);
        push_step(1 << RS);
        push_step((1 << RT) | (1 << UPD) | (1 << DN));
        md--;
      end
      2: begin
        for (int i = 0; i < LAT; i++) push_step(0);
        push_step(1 << WM);
        push_step(1 << ME);
        push_step((1 << RT) | (1 << UPD) | (1 << DN));
        md--;
      end
      3: begin
        for (int i = 0; i < LAT; i++) push_step(0);
        push_step(1 << RM);
        push_step((1 << WS) | (1 << RT) | (1 << 1));
        md++;
        push_step((1 << CS) | (1 << DN));
      end
      default: begin
        push_step((1 << RT) | (1 << SMT) | (1 << DN));
        md = tos;
      end
    endcase
  endtask

  // Starts and ends on a falling edge. Junk is driven on the command bus while busy.
  task automatic run_cmd(input int op, input int src, input int tos);
    int code;
    build(op, src, tos, code);
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_src   = 3'(src);
    cmd_tos   = AW'(tos);
    if (code != 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rej_ctrl", obs, 0);
      chk("rej_err_valid", err_valid, 1);
      chk("rej_err_code", err_code, code);
      chk("rej_depth", depth, md);
      chk("rej_ready", cmd_ready, 1);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        chk($sformatf("op%0d_ctrl[%0d]", op, i), obs, exp_q[i].word);
        chk($sformatf("op%0d_depth[%0d]", op, i), depth, exp_q[i].dep);
        chk("busy_ready", cmd_ready, 0);
        chk("busy_err", err_valid, 0);
        cmd_valid = (i < exp_q.size() - 1);
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_src   = 3'($urandom_range(0, 7));
        cmd_tos   = AW'($urandom);
      end
    end
    @(negedge clk);
    chk("idle_ctrl", obs, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_depth", depth, md);
    chk("idle_err", {err_valid, err_code}, 0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    md = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_op = '0; cmd_src = '0; cmd_tos = '0;
    do_reset();
    chk("reset_ctrl", obs, 0);
    chk("reset_depth", depth, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_err", {err_valid, err_code}, 0);

    run_cmd(1, 0, 0);                      // POP at depth 0 -> underflow
    run_cmd(0, 0, 0);                      // PUSH src 000
    for (int i = 0; i < 6; i++) run_cmd(0, i % 5, 0);
    chk("full_depth", depth, 7);
    run_cmd(0, 2, 0);                      // overflow
    run_cmd(3, 0, 0);                      // LOAD overflow
    run_cmd(4, 0, 2);                      // RESTORE to 2
    run_cmd(2, 0, 0);                      // STORE at depth 2
    run_cmd(3, 4, 0);                      // LOAD at depth 1, src ignored
    run_cmd(4, 0, 5);                      // RESTORE 5
    run_cmd(2, 0, 0);                      // STORE at 5 -> 4

    // Reset in the middle of a STORE (ST_WRITE cycle).
    cmd_valid = 1'b1; cmd_op = 3'd2;
    @(negedge clk); cmd_valid = 1'b0;      // RD_WAIT
    @(negedge clk);                        // ST_CAP
    @(negedge clk);                        // ST_WRITE
    chk("st_write_ctrl", obs, 1 << ME);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", obs, 0);
    chk("rst_mid_depth", depth, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    reset = 1'b0;
    md = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    run_cmd(7, 0, 0);                      // illegal op
    run_cmd(5, 0, 0);                      // illegal op

    for (int n = 0; n < 200; n++) begin
      int r, op;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 9: op = 0;
        3, 4:       op = 1;
        5:          op = 2;
        6:          op = 3;
        7:          op = 4;
        default:    op = $urandom_range(5, 7);
      endcase
      run_cmd(op, $urandom_range(0, 4), $urandom_range(0, MAXD));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
